// File: rtl/zoom_pkg.sv
// Shared widths, state encodings and the 2x2 average helper for zoom_out_media.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zoom_pkg;

   localparam int PIXEL_W = 8;   // pixel width
   localparam int SUM_W   = 9;   // horizontal pair sum stored between rows
   localparam int ACC_W   = 10;  // full four-pixel sum, cannot overflow

   // Row parity doubles as the FSM state: even rows collect sums, odd rows emit.
   localparam logic [0:0] S_PAR   = 1'b0;
   localparam logic [0:0] S_IMPAR = 1'b1;

   // Average of a stored pair sum and the two current-row pixels, truncated.
   function automatic logic [PIXEL_W-1:0] avg4(input logic [SUM_W-1:0]   pair_sum,
                                               input logic [PIXEL_W-1:0] a,
                                               input logic [PIXEL_W-1:0] b);
      logic [ACC_W-1:0] acc;
      acc = ACC_W'(pair_sum) + ACC_W'(a) + ACC_W'(b);
      return acc[ACC_W-1:2];
   endfunction

endpackage

// File: rtl/buffer_soma.sv
// Line buffer of horizontal pair sums from the even row of a row pair.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none, the caller qualifies wr_en.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr/rd_dat read port.
module buffer_soma
   import zoom_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [SUM_W-1:0] wr_dat,
   input  logic [AW-1:0]    rd_addr,
   output logic [SUM_W-1:0] rd_dat
);

   // Not reset: every entry is rewritten in the even row before the odd row reads it.
   logic [SUM_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/zoom_out_media.sv
// 2x2 averaging decimator with bypass; mode is chosen at the start of each row pair.
// Latency: one cycle from the completing input transfer to pixel_out.
// Backpressure: valid/ready; even zoom rows never stall, otherwise input stalls while output is held.
// Ports: clk, rst_n; enable_zoom_out; pixel_in/pixel_valid_in/pixel_ready_out upstream;
//        pixel_out/pixel_valid_out/pixel_ready_in downstream; row_done pulse on last pixel of a row.
module zoom_out_media
   import zoom_pkg::*;
#(
   parameter int IMAGE_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable_zoom_out,
   input  logic [PIXEL_W-1:0] pixel_in,
   input  logic               pixel_valid_in,
   output logic               pixel_ready_out,
   output logic [PIXEL_W-1:0] pixel_out,
   output logic               pixel_valid_out,
   input  logic               pixel_ready_in,
   output logic               row_done
);

   localparam int CW    = $clog2(IMAGE_WIDTH);
   localparam int DEPTH = IMAGE_WIDTH / 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]      col_cnt;
   logic [0:0]         row_par;
   logic               mode;
   logic [PIXEL_W-1:0] hold;
   logic               out_last;

   logic               col_last, col_odd, pair_start, eff_zoom;
   logic               in_xfer, out_xfer, load_out, buf_wr;
   logic [AW-1:0]      buf_addr;
   logic [SUM_W-1:0]   buf_wr_dat, buf_rd_dat;
   logic [PIXEL_W-1:0] next_out;

   assign col_last   = (col_cnt == CW'(IMAGE_WIDTH - 1));
   assign col_odd    = col_cnt[0];
   assign pair_start = (col_cnt == '0) && (row_par == S_PAR);

   // The pixel that samples the mode is already processed in the new mode.
   assign eff_zoom = pair_start ? enable_zoom_out : mode;

   // Even zoom rows only touch the buffer, so they never wait on downstream.
   assign pixel_ready_out = (eff_zoom && row_par == S_PAR) ? 1'b1
                                                           : (!pixel_valid_out || pixel_ready_in);

   assign in_xfer  = pixel_valid_in && pixel_ready_out;
   assign out_xfer = pixel_valid_out && pixel_ready_in;
   assign load_out = in_xfer && (!eff_zoom || (row_par == S_IMPAR && col_odd));

   assign buf_addr   = AW'(col_cnt >> 1);
   assign buf_wr     = in_xfer && eff_zoom && (row_par == S_PAR) && col_odd;
   assign buf_wr_dat = SUM_W'(hold) + SUM_W'(pixel_in);

   assign next_out = eff_zoom ? avg4(buf_rd_dat, hold, pixel_in) : pixel_in;

   buffer_soma #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk     (clk),
      .wr_en   (buf_wr),
      .wr_addr (buf_addr),
      .wr_dat  (buf_wr_dat),
      .rd_addr (buf_addr),
      .rd_dat  (buf_rd_dat)
   );

   // Position and mode tracking; only input transfers move it, so stalls preserve it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_par <= S_PAR;
         mode    <= 1'b0;
         hold    <= '0;
      end else if (in_xfer) begin
         if (pair_start) mode <= enable_zoom_out;
         if (!col_odd)   hold <= pixel_in;
         if (col_last) begin
            col_cnt <= '0;
            row_par <= ~row_par;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   // Output register: a load in the same cycle as an acceptance simply replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_out       <= '0;
         pixel_valid_out <= 1'b0;
         out_last        <= 1'b0;
      end else if (load_out) begin
         pixel_out       <= next_out;
         pixel_valid_out <= 1'b1;
         // Last input column ends an output row in both modes.
         out_last        <= col_last;
      end else if (out_xfer) begin
         pixel_valid_out <= 1'b0;
      end
   end

   assign row_done = out_xfer && out_last;

endmodule

// File: tb/tb_zoom_out_media.sv
// Directed bench for zoom_out_media at IMAGE_WIDTH=4.
// Latency: n/a.
// Backpressure: exercises downstream stall during an odd zoom row.
module tb_zoom_out_media;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable_zoom_out;
   logic [7:0] pixel_in;
   logic       pixel_valid_in;
   logic       pixel_ready_out;
   logic [7:0] pixel_out;
   logic       pixel_valid_out;
   logic       pixel_ready_in;
   logic       row_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   zoom_out_media #(.IMAGE_WIDTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable_zoom_out (enable_zoom_out),
      .pixel_in        (pixel_in),
      .pixel_valid_in  (pixel_valid_in),
      .pixel_ready_out (pixel_ready_out),
      .pixel_out       (pixel_out),
      .pixel_valid_out (pixel_valid_out),
      .pixel_ready_in  (pixel_ready_in),
      .row_done        (row_done)
   );

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present one pixel and return #1 after the edge that transferred it.
   task automatic push(input logic [7:0] p);
      bit done = 0;
      pixel_in       = p;
      pixel_valid_in = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         if (pixel_ready_out) done = 1;
         @(posedge clk);
         #1;
      end
      pixel_valid_in = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: pixel %0d observed=not accepted expected=accepted", p);
      end
   endtask

   // Push a pixel, then check the output state it produces.
   task automatic push_chk(input string tag, input logic [7:0] p,
                           input int exp_vld, input int exp_pix, input int exp_done);
      push(p);
      check({tag, "_vld"}, int'(pixel_valid_out), exp_vld);
      if (exp_vld != 0) check({tag, "_pix"}, int'(pixel_out), exp_pix);
      check({tag, "_done"}, int'(row_done), exp_done);
   endtask

   initial begin
      rst_n           = 1'b0;
      enable_zoom_out = 1'b1;
      pixel_in        = '0;
      pixel_valid_in  = 1'b0;
      pixel_ready_in  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld",   int'(pixel_valid_out), 0);
      check("rst_pix",   int'(pixel_out), 0);
      check("rst_done",  int'(row_done), 0);
      check("rst_ready", int'(pixel_ready_out), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic zoom: 10..40 / 50..80 -> 35, 55.
      push(10); push(20); push(30);
      push_chk("z1_even", 40, 0, 0, 0);
      push(50);
      push_chk("z1_o0", 60, 1, 35, 0);
      push_chk("z1_c2", 70, 0, 0, 0);
      push_chk("z1_o1", 80, 1, 55, 1);

      // Truncation: (1+2+0+0)>>2 = 0, (0+0+255+255)>>2 = 127.
      push(1); push(2); push(0); push(0);
      push(0);
      push_chk("trunc_o0", 0, 1, 0, 0);
      push(255);
      push_chk("trunc_o1", 255, 1, 127, 1);

      // Saturated input stays at 255.
      for (int i = 0; i < 5; i++) push(255);
      push_chk("max_o0", 255, 1, 255, 0);
      push(255);
      push_chk("max_o1", 255, 1, 255, 1);

      // Downstream stall for 5 cycles holding the first output.
      push(10); push(20); push(30); push(40);
      push(50);
      push(60);
      pixel_ready_in = 1'b0;
      pixel_in       = 70;
      pixel_valid_in = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("stall_pix",   int'(pixel_out), 35);
         check("stall_vld",   int'(pixel_valid_out), 1);
         check("stall_ready", int'(pixel_ready_out), 0);
         @(posedge clk);
         #1;
      end
      pixel_ready_in = 1'b1;
      #1;
      check("unstall_ready", int'(pixel_ready_out), 1);
      @(posedge clk);
      #1;
      pixel_valid_in = 1'b0;
      check("unstall_drain", int'(pixel_valid_out), 0);
      push_chk("stall_o1", 80, 1, 55, 1);

      // Bypass; enabling zoom at col 2 must not take effect until the next pair start.
      enable_zoom_out = 1'b0;
      push_chk("byp_0", 10, 1, 10, 0);
      push_chk("byp_1", 20, 1, 20, 0);
      enable_zoom_out = 1'b1;
      push_chk("byp_2", 30, 1, 30, 0);
      push_chk("byp_3", 40, 1, 40, 1);
      push_chk("byp_r1_0", 1, 1, 1, 0);
      push_chk("byp_r1_3", 2, 1, 2, 0);
      push_chk("byp_r1_2", 3, 1, 3, 0);
      push_chk("byp_r1_1", 4, 1, 4, 1);
      // New pair start with enable=1: even zoom row produces nothing.
      push_chk("mode_sw_0", 10, 0, 0, 0);
      push(20); push(30); push(40);
      push(50); push(60); push(70);
      check("pre_rst_pix", int'(pixel_out), 35);

      // Reset mid odd row, then a fresh pair must average correctly.
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld",  int'(pixel_valid_out), 0);
      check("mid_rst_pix",  int'(pixel_out), 0);
      check("mid_rst_done", int'(row_done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(12); push(20); push(100); push(200);
      push(4);
      push_chk("post_rst_o0", 8, 1, 11, 0);
      push(0);
      push_chk("post_rst_o1", 1, 1, 75, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
